// File: rtl/game_geom_pkg.sv
// Shared dino/obstacle geometry constants and the collision FSM state type.
package game_geom_pkg;

   localparam int unsigned HB_W        = 10;
   localparam int unsigned DINO_X1     = 150;
   localparam int unsigned DUCK_DX     = 50;
   localparam int unsigned JUMP_DX     = 10;
   localparam int unsigned STAND_DX    = 12;
   localparam int unsigned Y_TOP       = 354;
   localparam int unsigned Y_DUCK_TOP  = 374;
   localparam int unsigned Y_BOT       = 402;
   localparam int unsigned CACTUS_Y_LO = 370;
   localparam int unsigned CACTUS_Y_HI = 400;
   localparam int unsigned BIRD_Y_LO   = 332;
   localparam int unsigned BIRD_Y_HI   = 370;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      GRACE = 2'd1,
      OVER  = 2'd2
   } state_e;

endpackage

// File: rtl/obstacle_overlap.sv
// Horizontal overlap of N packed obstacle x-positions against an inclusive [x1, x2] window.
module obstacle_overlap #(
   parameter int unsigned N   = 1,
   parameter int unsigned X_W = 11
) (
   input  logic [N*X_W-1:0] i_x,
   input  logic [N-1:0]     i_valid,
   input  logic [X_W-1:0]   i_x1,
   input  logic [X_W-1:0]   i_x2,
   output logic             o_any_c
);

   always_comb begin
      o_any_c = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (i_valid[i] && (i_x[i*X_W +: X_W] >= i_x1) && (i_x[i*X_W +: X_W] <= i_x2)) begin
            o_any_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/collision_monitor.sv
// Per-frame dino/obstacle collision check with hit confirmation, lives, grace period
// and a latched game-over freeze.
module collision_monitor #(
   parameter int unsigned N_CACTUS       = 5,
   parameter int unsigned N_BIRD         = 1,
   parameter int unsigned X_W            = 11,
   parameter int unsigned Y_W            = 6,
   parameter int unsigned DINO_X1        = game_geom_pkg::DINO_X1,
   parameter int unsigned CONFIRM_FRAMES = 1,
   parameter int unsigned GRACE_FRAMES   = 60,
   parameter int unsigned LIVES          = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_tick,
   input  logic                    down,
   input  logic [Y_W-1:0]          jump_y,
   input  logic [N_CACTUS*X_W-1:0] cactus_x,
   input  logic [N_CACTUS-1:0]     cactus_valid,
   input  logic [N_BIRD*X_W-1:0]   bird_x,
   input  logic [N_BIRD-1:0]       bird_valid,
   input  logic                    restart,
   output logic                    freeze,
   output logic                    hit_pulse,
   output logic                    grace,
   output logic [2:0]              lives_left,
   output logic                    hit_is_bird
);

   import game_geom_pkg::*;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned GRACE_W = 8;
   localparam int unsigned LIVES_W = 3;

   // Stage 1: pose-dependent hitbox
   logic [HB_W-1:0] w_x2, w_y1, w_y2;
   logic [HB_W-1:0] r_x2, r_y1, r_y2;

   always_comb begin
      w_x2 = HB_W'(DINO_X1 + STAND_DX);
      w_y1 = HB_W'(Y_TOP);
      w_y2 = HB_W'(Y_BOT);
      if (down) begin
         w_x2 = HB_W'(DINO_X1 + DUCK_DX);
         w_y1 = HB_W'(Y_DUCK_TOP);
      end else if (jump_y != '0) begin
         w_x2 = HB_W'(DINO_X1 + JUMP_DX);
         w_y1 = HB_W'(Y_TOP) - HB_W'(jump_y);
         w_y2 = HB_W'(Y_BOT) - HB_W'(jump_y);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x2 <= HB_W'(DINO_X1 + STAND_DX);
         r_y1 <= HB_W'(Y_TOP);
         r_y2 <= HB_W'(Y_BOT);
      end else begin
         r_x2 <= w_x2;
         r_y1 <= w_y1;
         r_y2 <= w_y2;
      end
   end

   // Overlap against the registered hitbox
   logic [X_W-1:0] w_x1_ext, w_x2_ext;
   logic           w_cactus_x_hit, w_bird_x_hit;
   logic           w_cactus_hit, w_bird_hit, w_any_hit;

   assign w_x1_ext = X_W'(DINO_X1);
   assign w_x2_ext = X_W'(r_x2);

   obstacle_overlap #(.N(N_CACTUS), .X_W(X_W)) u_cactus_overlap (
      .i_x     (cactus_x),
      .i_valid (cactus_valid),
      .i_x1    (w_x1_ext),
      .i_x2    (w_x2_ext),
      .o_any_c (w_cactus_x_hit)
   );

   obstacle_overlap #(.N(N_BIRD), .X_W(X_W)) u_bird_overlap (
      .i_x     (bird_x),
      .i_valid (bird_valid),
      .i_x1    (w_x1_ext),
      .i_x2    (w_x2_ext),
      .o_any_c (w_bird_x_hit)
   );

   assign w_cactus_hit = w_cactus_x_hit && (r_y2 >= HB_W'(CACTUS_Y_LO)) && (r_y1 <= HB_W'(CACTUS_Y_HI));
   assign w_bird_hit   = w_bird_x_hit   && (r_y2 >= HB_W'(BIRD_Y_LO))   && (r_y1 <= HB_W'(BIRD_Y_HI));
   assign w_any_hit    = w_cactus_hit || w_bird_hit;

   // Game FSM
   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_confirm_cnt, w_confirm_nxt, w_confirm_inc;
   logic [GRACE_W-1:0]  r_grace_cnt, w_grace_cnt_nxt;
   logic [LIVES_W-1:0]  r_lives, w_lives_nxt;
   logic                r_freeze, w_freeze_nxt;
   logic                r_hit_pulse, w_hit_pulse_nxt;
   logic                r_grace, w_grace_nxt;
   logic                r_hit_is_bird, w_hit_is_bird_nxt;

   assign w_confirm_inc = r_confirm_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_confirm_cnt <= '0;
         r_grace_cnt   <= '0;
         r_lives       <= LIVES_W'(LIVES);
         r_freeze      <= 1'b0;
         r_hit_pulse   <= 1'b0;
         r_grace       <= 1'b0;
         r_hit_is_bird <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_confirm_cnt <= w_confirm_nxt;
         r_grace_cnt   <= w_grace_cnt_nxt;
         r_lives       <= w_lives_nxt;
         r_freeze      <= w_freeze_nxt;
         r_hit_pulse   <= w_hit_pulse_nxt;
         r_grace       <= w_grace_nxt;
         r_hit_is_bird <= w_hit_is_bird_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_confirm_nxt     = r_confirm_cnt;
      w_grace_cnt_nxt   = r_grace_cnt;
      w_lives_nxt       = r_lives;
      w_freeze_nxt      = r_freeze;
      w_hit_pulse_nxt   = 1'b0;
      w_grace_nxt       = r_grace;
      w_hit_is_bird_nxt = r_hit_is_bird;

      // restart overrides any evaluation on the same cycle
      if (restart) begin
         w_state_nxt     = RUN;
         w_confirm_nxt   = '0;
         w_grace_cnt_nxt = '0;
         w_lives_nxt     = LIVES_W'(LIVES);
         w_freeze_nxt    = 1'b0;
         w_grace_nxt     = 1'b0;
      end else if (frame_tick) begin
         case (r_state)
            RUN: begin
               if (!w_any_hit) begin
                  w_confirm_nxt = '0;
               end else if (w_confirm_inc != CNT_W'(CONFIRM_FRAMES)) begin
                  w_confirm_nxt = w_confirm_inc;
               end else begin
                  w_confirm_nxt     = '0;
                  w_hit_pulse_nxt   = 1'b1;
                  w_hit_is_bird_nxt = w_bird_hit;
                  if (r_lives <= LIVES_W'(1)) begin
                     w_lives_nxt  = '0;
                     w_state_nxt  = OVER;
                     w_freeze_nxt = 1'b1;
                  end else begin
                     w_lives_nxt     = r_lives - LIVES_W'(1);
                     w_state_nxt     = GRACE;
                     w_grace_cnt_nxt = GRACE_W'(GRACE_FRAMES);
                     w_grace_nxt     = 1'b1;
                  end
               end
            end
            GRACE: begin
               w_confirm_nxt   = '0;
               w_grace_cnt_nxt = r_grace_cnt - GRACE_W'(1);
               if (r_grace_cnt <= GRACE_W'(1)) begin
                  w_grace_cnt_nxt = '0;
                  w_state_nxt     = RUN;
                  w_grace_nxt     = 1'b0;
               end
            end
            OVER: begin
               w_state_nxt = OVER;
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end
   end

   assign freeze      = r_freeze;
   assign hit_pulse   = r_hit_pulse;
   assign grace       = r_grace;
   assign lives_left  = r_lives;
   assign hit_is_bird = r_hit_is_bird;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: three instances share stimulus, each with its own parameters.
module tb_collision_monitor;

   localparam int unsigned NC = 5;
   localparam int unsigned NB = 1;
   localparam int unsigned XW = 11;
   localparam int unsigned YW = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_tick;
   logic              down;
   logic [YW-1:0]     jump_y;
   logic [NC*XW-1:0]  cactus_x;
   logic [NC-1:0]     cactus_valid;
   logic [NB*XW-1:0]  bird_x;
   logic [NB-1:0]     bird_valid;
   logic              restart;

   logic       a_freeze, a_hit_pulse, a_grace, a_hit_is_bird;
   logic [2:0] a_lives;
   logic       b_freeze, b_hit_pulse, b_grace, b_hit_is_bird;
   logic [2:0] b_lives;
   logic       c_freeze, c_hit_pulse, c_grace, c_hit_is_bird;
   logic [2:0] c_lives;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // defaults: CONFIRM=1, GRACE=60, LIVES=3
   collision_monitor u_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .down(down), .jump_y(jump_y),
      .cactus_x(cactus_x), .cactus_valid(cactus_valid), .bird_x(bird_x), .bird_valid(bird_valid),
      .restart(restart), .freeze(a_freeze), .hit_pulse(a_hit_pulse), .grace(a_grace),
      .lives_left(a_lives), .hit_is_bird(a_hit_is_bird)
   );

   collision_monitor #(.GRACE_FRAMES(4)) u_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .down(down), .jump_y(jump_y),
      .cactus_x(cactus_x), .cactus_valid(cactus_valid), .bird_x(bird_x), .bird_valid(bird_valid),
      .restart(restart), .freeze(b_freeze), .hit_pulse(b_hit_pulse), .grace(b_grace),
      .lives_left(b_lives), .hit_is_bird(b_hit_is_bird)
   );

   collision_monitor #(.CONFIRM_FRAMES(3)) u_c (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .down(down), .jump_y(jump_y),
      .cactus_x(cactus_x), .cactus_valid(cactus_valid), .bird_x(bird_x), .bird_valid(bird_valid),
      .restart(restart), .freeze(c_freeze), .hit_pulse(c_hit_pulse), .grace(c_grace),
      .lives_left(c_lives), .hit_is_bird(c_hit_is_bird)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      step();
   endtask

   task automatic clear_obstacles();
      cactus_x     = '0;
      cactus_valid = '0;
      bird_x       = '0;
      bird_valid   = '0;
   endtask

   task automatic set_cactus(input int slot, input int unsigned x, input logic v);
      cactus_x[slot*XW +: XW] = XW'(x);
      cactus_valid[slot]      = v;
   endtask

   task automatic test_reset();
      checks++; if (a_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got=%b exp=0", a_freeze); end
      checks++; if (a_hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_hit_pulse got=%b exp=0", a_hit_pulse); end
      checks++; if (a_grace !== 1'b0) begin errors++; $display("FAIL reset_grace got=%b exp=0", a_grace); end
      checks++; if (a_lives !== 3'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", a_lives); end
      checks++; if (a_hit_is_bird !== 1'b0) begin errors++; $display("FAIL reset_hit_is_bird got=%b exp=0", a_hit_is_bird); end
      checks++; if (b_lives !== 3'd3 || c_lives !== 3'd3) begin
         errors++; $display("FAIL reset_lives_bc got=%0d/%0d exp=3/3", b_lives, c_lives);
      end
   endtask

   task automatic test_basic_hit();
      clear_obstacles();
      set_cactus(2, 155, 1'b1);
      step();
      do_tick();
      checks++; if (a_hit_pulse !== 1'b1) begin errors++; $display("FAIL basic_hit_pulse got=%b exp=1", a_hit_pulse); end
      checks++; if (a_lives !== 3'd2) begin errors++; $display("FAIL basic_lives got=%0d exp=2", a_lives); end
      checks++; if (a_grace !== 1'b1) begin errors++; $display("FAIL basic_grace got=%b exp=1", a_grace); end
      checks++; if (a_hit_is_bird !== 1'b0) begin errors++; $display("FAIL basic_hit_is_bird got=%b exp=0", a_hit_is_bird); end
      step();
      checks++; if (a_hit_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", a_hit_pulse); end
   endtask

   task automatic test_valid_and_x_boundary();
      int pulses;
      do_restart();
      clear_obstacles();
      set_cactus(2, 155, 1'b0);
      pulses = 0;
      for (int t = 0; t < 10; t++) begin
         do_tick();
         if (a_hit_pulse === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL invalid_slot_pulses got=%0d exp=0", pulses); end
      checks++; if (a_lives !== 3'd3) begin errors++; $display("FAIL invalid_slot_lives got=%0d exp=3", a_lives); end
      set_cactus(2, 163, 1'b1);
      do_tick();
      checks++; if (a_hit_pulse !== 1'b0) begin errors++; $display("FAIL x163_no_hit got=%b exp=0", a_hit_pulse); end
      set_cactus(2, 162, 1'b1);
      do_tick();
      checks++; if (a_hit_pulse !== 1'b1) begin errors++; $display("FAIL x162_hit got=%b exp=1", a_hit_pulse); end
   endtask

   task automatic test_pose();
      do_restart();
      clear_obstacles();
      jump_y = YW'(40);
      step();
      set_cactus(2, 155, 1'b1);
      do_tick();
      checks++; if (a_hit_pulse !== 1'b0) begin errors++; $display("FAIL jump_cactus_no_hit got=%b exp=0", a_hit_pulse); end
      clear_obstacles();
      bird_x = XW'(155); bird_valid = 1'b1;
      do_tick();
      checks++; if (a_hit_pulse !== 1'b1) begin errors++; $display("FAIL jump_bird_hit got=%b exp=1", a_hit_pulse); end
      checks++; if (a_hit_is_bird !== 1'b1) begin errors++; $display("FAIL jump_bird_src got=%b exp=1", a_hit_is_bird); end
      do_restart();
      clear_obstacles();
      jump_y = '0;
      down   = 1'b1;
      step();
      bird_x = XW'(190); bird_valid = 1'b1;
      do_tick();
      checks++; if (a_hit_pulse !== 1'b0) begin errors++; $display("FAIL duck_bird_no_hit got=%b exp=0", a_hit_pulse); end
      checks++; if (a_lives !== 3'd3) begin errors++; $display("FAIL duck_bird_lives got=%0d exp=3", a_lives); end
      clear_obstacles();
      set_cactus(0, 190, 1'b1);
      do_tick();
      checks++; if (a_hit_pulse !== 1'b1 || a_hit_is_bird !== 1'b0) begin
         errors++; $display("FAIL duck_cactus_hit got=%b/%b exp=1/0", a_hit_pulse, a_hit_is_bird);
      end
      down = 1'b0;
      clear_obstacles();
      step();
   endtask

   task automatic test_confirm();
      do_restart();
      clear_obstacles();
      for (int t = 1; t <= 6; t++) begin
         set_cactus(1, 155, (t != 3));
         do_tick();
         checks++; if (c_hit_pulse !== (t == 6)) begin
            errors++; $display("FAIL confirm_tick%0d got=%b exp=%b", t, c_hit_pulse, (t == 6));
         end
      end
      checks++; if (c_lives !== 3'd2) begin errors++; $display("FAIL confirm_lives got=%0d exp=2", c_lives); end
      clear_obstacles();
   endtask

   task automatic test_grace_to_over();
      logic       exp_pulse, exp_grace, exp_freeze;
      logic [2:0] exp_lives;
      do_restart();
      clear_obstacles();
      set_cactus(4, 155, 1'b1);
      for (int t = 1; t <= 16; t++) begin
         do_tick();
         exp_pulse  = (t == 1) || (t == 6) || (t == 11);
         exp_grace  = (t >= 1 && t <= 4) || (t >= 6 && t <= 9);
         exp_freeze = (t >= 11);
         exp_lives  = (t < 6) ? 3'd2 : (t < 11) ? 3'd1 : 3'd0;
         checks++; if (b_hit_pulse !== exp_pulse || b_grace !== exp_grace ||
                       b_freeze !== exp_freeze || b_lives !== exp_lives) begin
            errors++;
            $display("FAIL grace_tick%0d got pulse=%b grace=%b freeze=%b lives=%0d exp pulse=%b grace=%b freeze=%b lives=%0d",
                     t, b_hit_pulse, b_grace, b_freeze, b_lives, exp_pulse, exp_grace, exp_freeze, exp_lives);
         end
      end
   endtask

   task automatic test_restart_and_reset();
      // u_b is in OVER with overlap still present
      restart    = 1'b1;
      frame_tick = 1'b1;
      step();
      restart    = 1'b0;
      frame_tick = 1'b0;
      checks++; if (b_freeze !== 1'b0 || b_lives !== 3'd3 || b_hit_pulse !== 1'b0 || b_grace !== 1'b0) begin
         errors++; $display("FAIL restart_over got freeze=%b lives=%0d pulse=%b grace=%b exp 0/3/0/0",
                            b_freeze, b_lives, b_hit_pulse, b_grace);
      end
      do_tick();
      checks++; if (b_grace !== 1'b1 || b_lives !== 3'd2) begin
         errors++; $display("FAIL rehit_grace got grace=%b lives=%0d exp 1/2", b_grace, b_lives);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (b_grace !== 1'b0 || b_lives !== 3'd3 || b_hit_pulse !== 1'b0 || b_freeze !== 1'b0) begin
         errors++; $display("FAIL async_reset got grace=%b lives=%0d pulse=%b freeze=%b exp 0/3/0/0",
                            b_grace, b_lives, b_hit_pulse, b_freeze);
      end
      #1;
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      down       = 1'b0;
      jump_y     = '0;
      restart    = 1'b0;
      clear_obstacles();
      #12;
      test_reset();
      #1;
      rst_n = 1'b1;
      step();
      test_basic_hit();
      test_valid_and_x_boundary();
      test_pose();
      test_confirm();
      test_grace_to_over();
      test_restart_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
